// File: rtl/alu_frame_rx_pkg.sv
// Shared ALU package: operation codes, error flag layout, CRC step model and
// receiver FSM state encodings used by alu_frame_rx.
package alu_frame_rx_pkg;

  typedef enum logic [2:0] {
    and_op = 3'b000,
    or_op  = 3'b001,
    add_op = 3'b100,
    sub_op = 3'b101
  } operation_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  localparam logic [3:0] CRC_POLY_DEFAULT = 4'b0011;

  // err_flags = {ERR_DATA, ERR_CRC, ERR_OP}
  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;
  localparam logic [2:0] ERR_DATA_mask = 3'b100;
  localparam logic [2:0] ERR_CRC_mask  = 3'b010;
  localparam logic [2:0] ERR_OP_mask   = 3'b001;

  // One serial step of the x^4+x+1 CRC; starting from crc=0 gives the frame CRC.
  function automatic logic [3:0] crc_input(input logic [3:0] crc, input logic d,
                                           input logic [3:0] poly);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? poly : 4'b0000);
  endfunction

  typedef logic [2:0] rx_state_t;
  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_CTL    = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_STOP   = 3'd3;
  localparam rx_state_t ST_ABORT  = 3'd4;
  localparam rx_state_t ST_REPORT = 3'd5;

endpackage

// File: rtl/alu_frame_rx_crc.sv
// alu_crc4_serial: 4-bit serial LFSR with synchronous clear and bit enable.
module alu_crc4_serial
  import alu_frame_rx_pkg::*;
#(
  parameter logic [3:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 4'b0000;
    end else if (clr) begin
      crc <= 4'b0000;
    end else if (en) begin
      crc <= crc_input(crc, din, POLY);
    end
  end

endmodule

// File: rtl/alu_frame_rx.sv
// Serial ALU command receiver: deserialises operands and opcode, checks CRC on the fly.
// Optional feature macro: ALU_RX_TIMEOUT_EN (inter-frame idle timeout).
//
// state     | meaning
// IDLE      | line idle, waiting for a start bit
// CTL       | sampling the ctl bit (0 = data, 1 = cmd)
// DATA      | sampling 8 payload bits, MSB first
// STOP      | sampling the stop bit; cmd stop resolves the packet
// ABORT     | framing error, waiting for the line to return high
// REPORT    | result pulse cycle; also accepts the next start bit
module alu_frame_rx
  import alu_frame_rx_pkg::*;
#(
  parameter int         DATA_BYTES = 4,
  parameter logic [3:0] CRC_POLY   = CRC_POLY_DEFAULT,
  parameter int         TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sin,
  output logic [8*DATA_BYTES-1:0] a_out,
  output logic [8*DATA_BYTES-1:0] b_out,
  output operation_t              op_out,
  output logic                    frame_valid,
  output logic                    err_valid,
  output logic [2:0]              err_flags,
  output logic                    busy
);

  localparam int         W         = 8 * DATA_BYTES;
  localparam logic [3:0] BYTES     = 4'(2 * DATA_BYTES);
  localparam logic [3:0] BYTES_SAT = 4'(2 * DATA_BYTES + 1);

  rx_state_t      state;
  logic           ctl;
  logic [2:0]     bit_cnt;
  logic [3:0]     byte_cnt;
  logic [2*W-1:0] sreg;
  logic [6:0]     pl;
  logic [3:0]     crc;
  logic           cmd_done;
  logic           abort_done;
  logic           timeout_fire;
  logic           clr;
  logic           crc_en;
  logic           crc_din;

  assign cmd_done   = (state == ST_STOP) && sin && ctl;
  assign abort_done = (state == ST_ABORT) && sin;
  assign clr        = cmd_done | abort_done | timeout_fire;

  // In the cmd frame the leading 0 payload bit is replaced by the 1'b1 marker,
  // followed by the three OP bits; the received CRC bits are not fed.
  assign crc_en  = (state == ST_DATA) && (!ctl || (bit_cnt < 3'd4));
  assign crc_din = (ctl && (bit_cnt == 3'd0)) ? 1'b1 : sin;

  alu_crc4_serial #(.POLY(CRC_POLY)) u_crc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

`ifdef ALU_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= TW'(TIMEOUT);
    end else if ((state != ST_IDLE) || !busy) begin
      idle_cnt <= TW'(TIMEOUT);
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  assign timeout_fire = (state == ST_IDLE) && busy && sin && (idle_cnt == '0);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_fire   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ctl         <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 4'd0;
      sreg        <= '0;
      pl          <= 7'd0;
      a_out       <= '0;
      b_out       <= '0;
      op_out      <= and_op;
      frame_valid <= 1'b0;
      err_valid   <= 1'b0;
      err_flags   <= 3'b000;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_valid   <= 1'b0;
      case (state)
        ST_IDLE, ST_REPORT: begin
          if (!sin) begin
            state <= ST_CTL;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            if (timeout_fire) begin
              err_valid <= 1'b1;
              err_flags <= ERR_DATA_mask;
              busy      <= 1'b0;
            end
          end
        end
        ST_CTL: begin
          ctl     <= sin;
          bit_cnt <= 3'd0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          pl      <= {pl[5:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (!ctl && (byte_cnt < BYTES)) begin
            sreg <= {sreg[2*W-2:0], sin};
          end
          if (bit_cnt == 3'd7) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!sin) begin
            state <= ST_ABORT;
          end else if (!ctl) begin
            state <= ST_IDLE;
            if (byte_cnt != BYTES_SAT) begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else begin
            state <= ST_REPORT;
            busy  <= 1'b0;
            if (byte_cnt != BYTES) begin
              err_valid <= 1'b1;
              err_flags <= ERR_DATA_mask;
            end else if (crc != pl[3:0]) begin
              err_valid <= 1'b1;
              err_flags <= ERR_CRC_mask;
            end else if (!op_is_legal(pl[6:4])) begin
              err_valid <= 1'b1;
              err_flags <= ERR_OP_mask;
            end else begin
              frame_valid <= 1'b1;
              b_out       <= sreg[2*W-1:W];
              a_out       <= sreg[W-1:0];
              op_out      <= operation_t'(pl[6:4]);
            end
          end
        end
        ST_ABORT: begin
          if (sin) begin
            state     <= ST_IDLE;
            err_valid <= 1'b1;
            err_flags <= ERR_DATA_mask;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Packet resolution (pulse, abort or timeout) wipes partial packet state.
      if (clr) begin
        byte_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
        sreg     <= '0;
      end
    end
  end

endmodule
